adc16dv160_rx: RTL

Receive-side capture block for the ADC16DV160 8-lane DDR LVDS output. It sits in the ADC clock domain behind the lane input primitives (IBUFDS + IDDR in same-edge-pipelined mode), which deliver one rising-edge byte and one falling-edge byte per `clk`. The block reassembles each byte pair into a 16-bit sample and captures a programmed number of samples after an arm/trigger sequence. Captured samples go into a small FIFO drained by a valid/ready stream.

---
 rtl/adc16dv160_pkg.sv | 25 ++
 rtl/adc16dv160_rx_sync_fifo.sv | 58 +++++
 rtl/adc16dv160_rx.sv | 110 +++++++++++
 3 files changed

// File: rtl/adc16dv160_pkg.sv
// Shared types and helpers for the ADC16DV160 receive capture path.
// lanes_to_word interleaves the two DDR edges of each lane into one sample word.
package adc16dv160_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } rx_state_t;

  localparam int unsigned LANES = 8;

  function automatic logic [2*LANES-1:0] lanes_to_word(input logic [LANES-1:0] rise,
                                                       input logic [LANES-1:0] fall);
    logic [2*LANES-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w[2*k]   = rise[k];
      w[2*k+1] = fall[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/adc16dv160_rx_sync_fifo.sv
// First-word-fall-through FIFO with a registered output word.
// Occupancy counts the word currently presented, so DEPTH is the true capacity.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      used, left;
  logic             valid_q, pop, push;

  assign full       = (used == (AW+1)'(DEPTH));
  assign empty      = !valid_q;
  assign pop        = valid_q && rd;
  // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push       = wr_en && (!full || pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign left       = used - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      used    <= '0;
      valid_q <= 1'b0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      used    <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr_nxt;
      used    <= used + (AW+1)'(push) - (AW+1)'(pop);
      // Head is reloaded only from words already stored, which keeps it stable while stalled.
      valid_q <= (left != '0);
      if (left != '0) rd_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/adc16dv160_rx.sv
// ADC16DV160 receive capture: reassembles DDR lane bytes into 16-bit samples and
// stores a programmed number of them after arm/trigger into an output stream FIFO.
module adc16dv160_rx
  import adc16dv160_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] d_rise,
  input  logic [LANES-1:0] d_fall,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);
  rx_state_t        state, state_nxt;
  logic [LANES-1:0] rise_q, fall_q;
  logic [15:0]      w_q;
  logic [CNT_W-1:0] len_q;
  logic             lead, wr, full, empty, drop, start;

  assign start   = arm && (state == IDLE || state == DONE);
  assign m_valid = !empty;
  assign drop    = wr && full && !(m_valid && m_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      w_q    <= '0;
    end else begin
      rise_q <= d_rise;
      fall_q <= d_fall;
      w_q    <= lanes_to_word(rise_q, fall_q);
    end
  end

  // lead marks the first CAPTURE cycle, whose w_q still predates the trigger sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lead  <= 1'b0;
    end else begin
      state <= state_nxt;
      lead  <= (state == ARMED) && trig && !abort;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) state_nxt = (len == '0) ? DONE : ARMED;
        ARMED:      if (trig) state_nxt = CAPTURE;
        CAPTURE:    if (wr && (count + CNT_W'(1) == len_q)) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARMED) || (state == CAPTURE);
    done = (state == DONE);
    wr   = (state == CAPTURE) && !lead && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (abort) begin
      len_q <= len_q;
    end else if (start) begin
      len_q    <= len;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr && count != len_q) count <= count + CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(16)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (abort),
    .wr_en  (wr),
    .wr_data(w_q),
    .full   (full),
    .rd     (m_ready),
    .rd_data(m_data),
    .empty  (empty)
  );

endmodule
